// File: rtl/nios_core_dpram_pkg.sv
// Shared definitions for the nios_core_dpram dual-port RAM: parameter
// legality checks, byte-count and per-byte parity helpers, latency limits
// and the decoded request type used by each port.
package nios_core_dpram_pkg;

    localparam int unsigned MIN_DATA_W       = 8;
    localparam int unsigned MAX_DATA_W       = 128;
    localparam int unsigned MAX_BYTES        = MAX_DATA_W / 8;
    localparam int unsigned MAX_ADDR_W       = 24;
    localparam int unsigned MIN_READ_LATENCY = 1;
    localparam int unsigned MAX_READ_LATENCY = 2;

    // What a port is asking for in the current cycle; write wins over read.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } op_e;

    function automatic bit data_w_legal(input int unsigned w);
        return (w % 8 == 0) && (w >= MIN_DATA_W) && (w <= MAX_DATA_W);
    endfunction

    function automatic bit addr_w_legal(input int unsigned a);
        return (a >= 1) && (a <= MAX_ADDR_W);
    endfunction

    function automatic bit read_latency_legal(input int unsigned l);
        return (l >= MIN_READ_LATENCY) && (l <= MAX_READ_LATENCY);
    endfunction

    function automatic int unsigned byte_count(input int unsigned w);
        return w / 8;
    endfunction

    // Even parity per byte: each bit makes its byte plus parity hold an even
    // number of ones. Callers zero-extend narrower data and keep the low lanes.
    function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_DATA_W-1:0] data);
        logic [MAX_BYTES-1:0] par;
        par = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/nios_core_dpram_if.sv
// Avalon-MM style slave bus for one port of nios_core_dpram.
// The master modport is the requester side, the slave modport the RAM side.
interface nios_core_dpram_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;
    logic                parity_err;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest, parity_err
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest, parity_err
    );
endinterface

// File: rtl/nios_core_dpram_port.sv
// One port of nios_core_dpram: request decode and handshake, the
// READ_LATENCY-deep read pipeline and, when NIOS_CORE_DPRAM_PARITY_EN is
// defined, the per-byte parity check with a sticky error flag.
module nios_core_dpram_port
    import nios_core_dpram_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                freeze,
    input  logic                collide_stall,
    nios_core_dpram_if.slave    bus,
    input  logic [DATA_W-1:0]   mem_rdata,
`ifdef NIOS_CORE_DPRAM_PARITY_EN
    input  logic [DATA_W/8-1:0] mem_rpar,
`endif
    output logic                wr_en,
    output logic                rd_en
);

    localparam int unsigned NB = byte_count(DATA_W);

    op_e op;

    // Decode the request; read together with write counts as a write.
    always_comb begin
        // NOTE: op gets a default before any branch so no path leaves it
        // unassigned, which would otherwise infer a latch.
        op = OP_IDLE;
        if (bus.chipselect) begin
            if (bus.write) begin
                op = OP_WRITE;
            end else if (bus.read) begin
                op = OP_READ;
            end
        end
    end

    assign bus.waitrequest = freeze | collide_stall;
    assign wr_en           = (op == OP_WRITE) && !bus.waitrequest;
    assign rd_en           = (op == OP_READ)  && !bus.waitrequest;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_W-1:0]       pipe_data [READ_LATENCY];

    // Read pipeline; each stage loads only when it carries a read, so the
    // final stage holds readdata steady between valid pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: registered state uses non-blocking assignments so every
            // stage samples the value its predecessor had before the edge.
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_en;
            if (rd_en) begin
                pipe_data[0] <= mem_rdata;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign bus.readdata      = pipe_data[READ_LATENCY-1];
    assign bus.readdatavalid = pipe_valid[READ_LATENCY-1];

`ifdef NIOS_CORE_DPRAM_PARITY_EN
    logic [NB-1:0]         pipe_par [READ_LATENCY];
    logic [NB-1:0]         calc_par;
    logic [MAX_DATA_W-1:0] rd_ext;
    logic [MAX_BYTES-1:0]  rd_par_full;
    logic                  par_err_q;

    // Stored parity travels alongside its data through the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_par[i] <= '0;
            end
        end else begin
            if (rd_en) begin
                pipe_par[0] <= mem_rpar;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                if (pipe_valid[i-1]) begin
                    pipe_par[i] <= pipe_par[i-1];
                end
            end
        end
    end

    // Recompute parity on the data being returned.
    always_comb begin
        rd_ext              = '0;
        rd_ext[DATA_W-1:0]  = bus.readdata;
        rd_par_full         = byte_parity(rd_ext);
        calc_par            = rd_par_full[NB-1:0];
    end

    // Sticky error: set by any mismatching returned word, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
        end else if (bus.readdatavalid && (calc_par != pipe_par[READ_LATENCY-1])) begin
            par_err_q <= 1'b1;
        end
    end

    assign bus.parity_err = par_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: rtl/nios_core_dpram.sv
// Dual-port word RAM with byte enables, configurable read latency, a
// same-address write collision stall on port 2 and an optional per-byte
// parity check enabled by defining NIOS_CORE_DPRAM_PARITY_EN.
module nios_core_dpram
    import nios_core_dpram_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             freeze,
    nios_core_dpram_if.slave s1,
    nios_core_dpram_if.slave s2
);

    localparam int unsigned NB    = byte_count(DATA_W);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("nios_core_dpram: DATA_W must be a multiple of 8 in 8..128");
    end
    if (!addr_w_legal(ADDR_W)) begin : g_bad_addr_w
        $error("nios_core_dpram: ADDR_W out of range");
    end
    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("nios_core_dpram: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic              collide;
    logic              wr_en_s1, rd_en_s1, wr_en_s2, rd_en_s2;
    logic [DATA_W-1:0] rdata_s1, rdata_s2;

    // Both ports writing one word in the same cycle: port 1 wins, port 2 waits.
    assign collide = s1.chipselect && s1.write && s2.chipselect && s2.write
                     && (s1.address == s2.address);

    // Asynchronous array read sampled at acceptance: a same-cycle write from
    // the other port lands at the edge, so the read sees the old word.
    assign rdata_s1 = mem[s1.address];
    assign rdata_s2 = mem[s2.address];

    // Byte-lane writes from both ports; the collision stall keeps them on
    // different words whenever both are enabled.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset: contents survive
        // reset_n and power up undefined, which also lets it map onto RAM.
        for (int b = 0; b < NB; b++) begin
            if (wr_en_s1 && s1.byteenable[b]) begin
                mem[s1.address][8*b +: 8] <= s1.writedata[8*b +: 8];
            end
            if (wr_en_s2 && s2.byteenable[b]) begin
                mem[s2.address][8*b +: 8] <= s2.writedata[8*b +: 8];
            end
        end
    end

`ifdef NIOS_CORE_DPRAM_PARITY_EN
    logic [NB-1:0]         mem_par [DEPTH];
    logic [NB-1:0]         wpar_s1, wpar_s2;
    logic [MAX_DATA_W-1:0] wext_s1, wext_s2;
    logic [MAX_BYTES-1:0]  wpar_full_s1, wpar_full_s2;

    // Parity of the incoming write data, one bit per byte lane.
    always_comb begin
        wext_s1             = '0;
        wext_s2             = '0;
        wext_s1[DATA_W-1:0] = s1.writedata;
        wext_s2[DATA_W-1:0] = s2.writedata;
        wpar_full_s1        = byte_parity(wext_s1);
        wpar_full_s2        = byte_parity(wext_s2);
        wpar_s1             = wpar_full_s1[NB-1:0];
        wpar_s2             = wpar_full_s2[NB-1:0];
    end

    // Parity bits follow exactly the byte lanes written.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_en_s1 && s1.byteenable[b]) begin
                mem_par[s1.address][b] <= wpar_s1[b];
            end
            if (wr_en_s2 && s2.byteenable[b]) begin
                mem_par[s2.address][b] <= wpar_s2[b];
            end
        end
    end
`endif

    nios_core_dpram_port #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_port1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .freeze        (freeze),
        .collide_stall (1'b0),
        .bus           (s1),
        .mem_rdata     (rdata_s1),
`ifdef NIOS_CORE_DPRAM_PARITY_EN
        .mem_rpar      (mem_par[s1.address]),
`endif
        .wr_en         (wr_en_s1),
        .rd_en         (rd_en_s1)
    );

    nios_core_dpram_port #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_port2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .freeze        (freeze),
        .collide_stall (collide),
        .bus           (s2),
        .mem_rdata     (rdata_s2),
`ifdef NIOS_CORE_DPRAM_PARITY_EN
        .mem_rpar      (mem_par[s2.address]),
`endif
        .wr_en         (wr_en_s2),
        .rd_en         (rd_en_s2)
    );

endmodule

// File: tb/tb_nios_core_dpram.sv
// Self-checking bench for nios_core_dpram. Two instances (READ_LATENCY 1
// and 2) see identical stimulus and are compared every cycle against a
// word-array reference model with a per-cycle schedule of expected reads.
// Parity checks run when NIOS_CORE_DPRAM_PARITY_EN is defined.
module tb_nios_core_dpram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam int NB     = DATA_W / 8;
    localparam int SPAN   = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic freeze = 1'b0;

    logic [ADDR_W-1:0] addr  [2];
    logic [NB-1:0]     be    [2];
    logic              cs    [2];
    logic              rd    [2];
    logic              wr    [2];
    logic [DATA_W-1:0] wdata [2];

    logic [DATA_W-1:0] rdata  [2][2];
    logic              rvalid [2][2];
    logic              wreq   [2][2];
    logic              perr   [2][2];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        nios_core_dpram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_s1 ();
        nios_core_dpram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_s2 ();

        assign bus_s1.address    = addr[0];
        assign bus_s1.byteenable = be[0];
        assign bus_s1.chipselect = cs[0];
        assign bus_s1.read       = rd[0];
        assign bus_s1.write      = wr[0];
        assign bus_s1.writedata  = wdata[0];
        assign bus_s2.address    = addr[1];
        assign bus_s2.byteenable = be[1];
        assign bus_s2.chipselect = cs[1];
        assign bus_s2.read       = rd[1];
        assign bus_s2.write      = wr[1];
        assign bus_s2.writedata  = wdata[1];

        assign rdata[d][0]  = bus_s1.readdata;
        assign rvalid[d][0] = bus_s1.readdatavalid;
        assign wreq[d][0]   = bus_s1.waitrequest;
        assign perr[d][0]   = bus_s1.parity_err;
        assign rdata[d][1]  = bus_s2.readdata;
        assign rvalid[d][1] = bus_s2.readdatavalid;
        assign wreq[d][1]   = bus_s2.waitrequest;
        assign perr[d][1]   = bus_s2.parity_err;

        nios_core_dpram #(
            .DATA_W       (DATA_W),
            .ADDR_W       (ADDR_W),
            .READ_LATENCY (d + 1)
        ) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .freeze  (freeze),
            .s1      (bus_s1),
            .s2      (bus_s2)
        );
    end

    // Reference model state.
    logic [DATA_W-1:0] model_mem [SPAN];
    bit                due_v [2][2][4];
    logic [DATA_W-1:0] due_d [2][2][4];
    logic [DATA_W-1:0] last_d [2][2];
    bit   [1:0]        exp_perr;
    bit                perr_known;
    int                cycle;
    int                vectors;
    int                miscompares;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic set_req(input int p, input bit r, input bit w, input int a,
                           input logic [NB-1:0] b, input logic [DATA_W-1:0] dat);
        cs[p]    = r | w;
        rd[p]    = r;
        wr[p]    = w;
        addr[p]  = ADDR_W'(a);
        be[p]    = b;
        wdata[p] = dat;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            set_req(p, 1'b0, 1'b0, 0, '0, '0);
        end
        freeze = 1'b0;
    endtask

    // One clock cycle: called just after a negedge with inputs set, returns
    // at the next negedge. Checks waitrequest before the edge and read
    // outputs after it.
    task automatic step(output bit [1:0] stalled);
        bit   [1:0]        wt;
        bit   [1:0]        acc_rd;
        bit   [1:0]        acc_wr;
        logic [DATA_W-1:0] rv [2];
        int                slot;
        #1;
        wt[0] = freeze;
        wt[1] = freeze || (cs[0] && wr[0] && cs[1] && wr[1] && (addr[0] == addr[1]));
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("waitrequest lat%0d s%0d", d + 1, p + 1), wreq[d][p], wt[p]);
            end
        end
        for (int p = 0; p < 2; p++) begin
            acc_wr[p] = cs[p] && wr[p] && !wt[p];
            acc_rd[p] = cs[p] && rd[p] && !wr[p] && !wt[p];
            rv[p]     = model_mem[addr[p][5:0]];
        end
        for (int p = 0; p < 2; p++) begin
            if (acc_wr[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[p][b]) model_mem[addr[p][5:0]][8*b +: 8] = wdata[p][8*b +: 8];
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (acc_rd[p]) begin
                    slot = (cycle + d + 1) % 4;
                    due_v[d][p][slot] = 1'b1;
                    due_d[d][p][slot] = rv[p];
                end
            end
        end
        stalled = wt;
        @(posedge clk);
        cycle++;
        #1;
        slot = cycle % 4;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (due_v[d][p][slot]) last_d[d][p] = due_d[d][p][slot];
                check($sformatf("readdatavalid lat%0d s%0d", d + 1, p + 1),
                      rvalid[d][p], due_v[d][p][slot]);
                check($sformatf("readdata lat%0d s%0d", d + 1, p + 1), rdata[d][p], last_d[d][p]);
                if (perr_known) begin
                    check($sformatf("parity_err lat%0d s%0d", d + 1, p + 1), perr[d][p], exp_perr[p]);
                end
                due_v[d][p][slot] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Assert reset at a negedge, check the reset state, release n cycles later.
    task automatic apply_reset(input int n);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < 4; s++) due_v[d][p][s] = 1'b0;
                last_d[d][p] = '0;
            end
        end
        exp_perr   = '0;
        perr_known = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("reset readdatavalid lat%0d s%0d", d + 1, p + 1), rvalid[d][p], '0);
                check($sformatf("reset readdata lat%0d s%0d", d + 1, p + 1), rdata[d][p], '0);
                check($sformatf("reset parity_err lat%0d s%0d", d + 1, p + 1), perr[d][p], '0);
            end
        end
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic idle_steps(input int n);
        bit [1:0] st;
        idle_inputs();
        repeat (n) step(st);
    endtask

    initial begin
        bit [1:0] stalled;
        bit [1:0] held;
        int       hi;

        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        perr_known  = 1'b1;
        exp_perr    = '0;
        held        = '0;
        idle_inputs();
        @(negedge clk);
        apply_reset(3);

        // Give every model address a known value.
        for (int a = 0; a < SPAN; a++) begin
            set_req(0, 1'b0, 1'b1, a, '1, $urandom);
            step(stalled);
        end
        idle_steps(1);

        // Random traffic on both ports; stalled requests are held unchanged.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!held[p]) begin
                    hi = ($urandom_range(0, 1) != 0) ? 3 : SPAN - 1;
                    cs[p]    = ($urandom_range(0, 3) != 0);
                    rd[p]    = $urandom_range(0, 1) != 0;
                    wr[p]    = $urandom_range(0, 1) != 0;
                    addr[p]  = ADDR_W'($urandom_range(0, hi));
                    be[p]    = NB'($urandom);
                    wdata[p] = $urandom;
                end
            end
            freeze = ($urandom_range(0, 7) == 0);
            step(stalled);
            for (int p = 0; p < 2; p++) begin
                held[p] = stalled[p] && cs[p] && (rd[p] || wr[p]);
            end
        end
        idle_steps(3);

        // Write on port 1, read back on port 2.
        set_req(0, 1'b0, 1'b1, 'h010, 4'hF, 32'hDEADBEEF);
        step(stalled);
        idle_inputs();
        set_req(1, 1'b1, 1'b0, 'h010, 4'hF, '0);
        step(stalled);
        idle_steps(2);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("s2 read after s1 write lat%0d", d + 1), rdata[d][1], 32'hDEADBEEF);
        end

        // Same-address write collision: port 2 stalls once, then commits last.
        set_req(0, 1'b0, 1'b1, 'h020, 4'hF, 32'h11111111);
        set_req(1, 1'b0, 1'b1, 'h020, 4'hF, 32'h22222222);
        step(stalled);
        set_req(0, 1'b0, 1'b0, 0, '0, '0);
        step(stalled);
        set_req(1, 1'b1, 1'b0, 'h020, 4'hF, '0);
        step(stalled);
        idle_steps(2);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("collision final word lat%0d", d + 1), rdata[d][1], 32'h22222222);
        end

        // Partial write on byte lane 1 only.
        set_req(0, 1'b0, 1'b1, 'h005, 4'hF, 32'hAABBCCDD);
        step(stalled);
        set_req(0, 1'b0, 1'b1, 'h005, 4'h2, 32'h0000EE00);
        step(stalled);
        set_req(0, 1'b1, 1'b0, 'h005, 4'hF, '0);
        step(stalled);
        idle_steps(2);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("byte lane merge lat%0d", d + 1), rdata[d][0], 32'hAABBEEDD);
        end

        // Four back-to-back reads; the schedule checks every cycle for gaps.
        set_req(0, 1'b1, 1'b0, 'h010, 4'hF, '0);
        step(stalled);
        set_req(0, 1'b1, 1'b0, 'h020, 4'hF, '0);
        step(stalled);
        set_req(0, 1'b1, 1'b0, 'h005, 4'hF, '0);
        step(stalled);
        set_req(0, 1'b1, 1'b0, 'h011, 4'hF, '0);
        step(stalled);
        idle_steps(3);

        // Reset with two reads in flight on the latency-2 instance.
        set_req(0, 1'b1, 1'b0, 'h010, 4'hF, '0);
        set_req(1, 1'b1, 1'b0, 'h020, 4'hF, '0);
        step(stalled);
        apply_reset(2);
        idle_steps(4);
        set_req(0, 1'b1, 1'b0, 'h010, 4'hF, '0);
        set_req(1, 1'b1, 1'b0, 'h020, 4'hF, '0);
        step(stalled);
        idle_steps(2);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("contents kept through reset s1 lat%0d", d + 1), rdata[d][0], 32'hDEADBEEF);
            check($sformatf("contents kept through reset s2 lat%0d", d + 1), rdata[d][1], 32'h22222222);
        end

`ifdef NIOS_CORE_DPRAM_PARITY_EN
        // Corrupt one stored bit in byte 0; readdata stays raw, s1 flags it.
        g_dut[0].dut.mem[16][0] = ~g_dut[0].dut.mem[16][0];
        g_dut[1].dut.mem[16][0] = ~g_dut[1].dut.mem[16][0];
        model_mem[16][0] = ~model_mem[16][0];
        perr_known = 1'b0;
        set_req(0, 1'b1, 1'b0, 'h010, 4'hF, '0);
        step(stalled);
        idle_steps(4);
        exp_perr   = 2'b01;
        perr_known = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("corrupted word returned lat%0d", d + 1), rdata[d][0], 32'hDEADBEEE);
        end
        idle_steps(4);
        apply_reset(2);
        idle_steps(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "timeout");
    end

endmodule
